// File: rtl/pc_control.sv
// Fetch-stage program counter: sequential advance, B/BR targets, branch
// resolution against ALU flags, one-cycle flush after a taken branch, HLT freeze.
module pc_control #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        halt_dec,
  input  logic        branch_en,
  input  logic        branch_reg,
  input  logic [2:0]  cond,
  input  logic        flag_n,
  input  logic        flag_z,
  input  logic        flag_v,
  input  logic [8:0]  imm,
  input  logic [15:0] reg_target,
  output logic [15:0] pc_curr,
  output logic [15:0] pc_plus2,
  output logic        flush,
  output logic        halted
);

  typedef enum logic [1:0] {
    RUN,
    FLUSH,
    HALT
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [15:0] pc_nx;
  logic [15:0] b_target;
  logic [15:0] br_target;
  logic [15:0] target;
  logic        cond_true;
  logic        taken;
  logic        unused_lsb;

  assign pc_plus2   = pc_curr + 16'd2;
  assign b_target   = pc_plus2 + {{6{imm[8]}}, imm, 1'b0};
  assign br_target  = {reg_target[15:1], 1'b0};
  assign target     = branch_reg ? br_target : b_target;
  // BR targets are forced halfword-aligned, so the operand's LSB is dropped
  assign unused_lsb = reg_target[0];

  always_comb begin
    cond_true = 1'b0;
    unique case (cond)
      3'b000: cond_true = !flag_z;
      3'b001: cond_true = flag_z;
      3'b010: cond_true = !flag_z && !flag_n;
      3'b011: cond_true = flag_n;
      3'b100: cond_true = flag_z || (!flag_z && !flag_n);
      3'b101: cond_true = flag_n || flag_z;
      3'b110: cond_true = flag_v;
      3'b111: cond_true = 1'b1;
    endcase
  end

  assign taken = branch_en && cond_true;

  always_comb begin
    state_nx = state;
    pc_nx    = pc_curr;
    unique case (state)
      RUN: begin
        if (stall) begin
          state_nx = RUN;
        end else if (halt_dec) begin
          state_nx = HALT;
        end else if (taken) begin
          state_nx = FLUSH;
          pc_nx    = target;
        end else begin
          pc_nx    = pc_plus2;
        end
      end
      FLUSH: begin
        // the squashed slot's branch/halt decode is ignored
        if (!stall) begin
          state_nx = RUN;
          pc_nx    = pc_plus2;
        end
      end
      HALT: begin
        state_nx = HALT;
      end
      default: begin
        state_nx = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      pc_curr <= RESET_PC;
      flush   <= 1'b0;
      halted  <= 1'b0;
    end else begin
      state   <= state_nx;
      pc_curr <= pc_nx;
      flush   <= (state_nx == FLUSH);
      halted  <= (state_nx == HALT);
    end
  end

endmodule

// File: tb/tb_pc_control.sv
// Directed bench for pc_control: reset, sequential fetch, branch conditions,
// stall interaction, wrap-around, flush and halt behaviour.
module tb_pc_control;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        halt_dec;
  logic        branch_en;
  logic        branch_reg;
  logic [2:0]  cond;
  logic        flag_n;
  logic        flag_z;
  logic        flag_v;
  logic [8:0]  imm;
  logic [15:0] reg_target;
  logic [15:0] pc_curr;
  logic [15:0] pc_plus2;
  logic        flush;
  logic        halted;

  int checks;
  int failures;

  pc_control #(.RESET_PC(16'h0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .halt_dec   (halt_dec),
    .branch_en  (branch_en),
    .branch_reg (branch_reg),
    .cond       (cond),
    .flag_n     (flag_n),
    .flag_z     (flag_z),
    .flag_v     (flag_v),
    .imm        (imm),
    .reg_target (reg_target),
    .pc_curr    (pc_curr),
    .pc_plus2   (pc_plus2),
    .flush      (flush),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall      = 1'b0;
    halt_dec   = 1'b0;
    branch_en  = 1'b0;
    branch_reg = 1'b0;
    cond       = 3'b000;
    flag_n     = 1'b0;
    flag_z     = 1'b0;
    flag_v     = 1'b0;
    imm        = 9'h000;
    reg_target = 16'h0000;
  endtask

  task automatic check_st(input string tag,
                          input logic [15:0] pc,
                          input logic fl,
                          input logic hl);
    check({tag, ".pc"}, pc_curr, pc);
    check({tag, ".flush"}, {15'd0, flush}, {15'd0, fl});
    check({tag, ".halted"}, {15'd0, halted}, {15'd0, hl});
  endtask

  // Land on addr in RUN: BR to addr-2, then the flush cycle adds 2.
  task automatic goto(input logic [15:0] addr);
    branch_en  = 1'b1;
    branch_reg = 1'b1;
    cond       = 3'b111;
    reg_target = addr - 16'd2;
    step();
    idle();
    step();
    check("goto", pc_curr, addr);
  endtask

  typedef struct {
    logic [2:0] c;
    logic       n;
    logic       z;
    logic       v;
    logic       tk;
  } cvec_t;

  cvec_t cv[19];
  logic [15:0] epc;

  initial begin
    checks   = 0;
    failures = 0;
    idle();
    rst = 1'b1;

    // 1. reset and sequential fetch
    step();
    step();
    check_st("reset", 16'h0000, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    check_st("seq1", 16'h0002, 1'b0, 1'b0);
    step();
    check_st("seq2", 16'h0004, 1'b0, 1'b0);
    step();
    check_st("seq3", 16'h0006, 1'b0, 1'b0);
    check("plus2", pc_plus2, 16'h0008);

    // 2. B uncond, imm=-1 -> branch to self
    goto(16'h0010);
    branch_en = 1'b1;
    cond      = 3'b111;
    imm       = 9'h1FF;
    step();
    idle();
    check_st("b_self", 16'h0010, 1'b1, 1'b0);
    step();
    check_st("b_self_post", 16'h0012, 1'b0, 1'b0);

    // 3. EQ not taken / taken
    goto(16'h0020);
    branch_en = 1'b1;
    cond      = 3'b001;
    imm       = 9'd4;
    step();
    idle();
    check_st("eq_nt", 16'h0022, 1'b0, 1'b0);
    goto(16'h0020);
    branch_en = 1'b1;
    cond      = 3'b001;
    flag_z    = 1'b1;
    imm       = 9'd4;
    step();
    idle();
    check_st("eq_t", 16'h002A, 1'b1, 1'b0);
    step();

    // 4. BR aligns target; stalled branch not taken
    branch_en  = 1'b1;
    branch_reg = 1'b1;
    cond       = 3'b111;
    reg_target = 16'h1235;
    step();
    idle();
    check_st("br", 16'h1234, 1'b1, 1'b0);
    step();
    check_st("br_post", 16'h1236, 1'b0, 1'b0);
    branch_en = 1'b1;
    cond      = 3'b111;
    imm       = 9'd4;
    stall     = 1'b1;
    step();
    idle();
    check_st("stall_b", 16'h1236, 1'b0, 1'b0);
    step();
    check_st("after_stall", 16'h1238, 1'b0, 1'b0);

    // stall during FLUSH holds flush high
    branch_en = 1'b1;
    cond      = 3'b111;
    step();
    idle();
    check_st("fl_a", 16'h123A, 1'b1, 1'b0);
    stall = 1'b1;
    step();
    check_st("fl_stall", 16'h123A, 1'b1, 1'b0);
    stall = 1'b0;
    step();
    check_st("fl_done", 16'h123C, 1'b0, 1'b0);

    // halt_dec ignored in FLUSH slot
    branch_en = 1'b1;
    cond      = 3'b111;
    step();
    idle();
    halt_dec = 1'b1;
    step();
    idle();
    check_st("fl_halt_ign", 16'h1240, 1'b0, 1'b0);

    // condition table, B with imm=+4
    cv[0]  = '{3'b000, 1'b0, 1'b0, 1'b0, 1'b1};
    cv[1]  = '{3'b000, 1'b0, 1'b1, 1'b0, 1'b0};
    cv[2]  = '{3'b001, 1'b0, 1'b1, 1'b0, 1'b1};
    cv[3]  = '{3'b001, 1'b0, 1'b0, 1'b0, 1'b0};
    cv[4]  = '{3'b010, 1'b0, 1'b0, 1'b0, 1'b1};
    cv[5]  = '{3'b010, 1'b1, 1'b0, 1'b0, 1'b0};
    cv[6]  = '{3'b010, 1'b0, 1'b1, 1'b0, 1'b0};
    cv[7]  = '{3'b011, 1'b1, 1'b0, 1'b0, 1'b1};
    cv[8]  = '{3'b011, 1'b0, 1'b0, 1'b0, 1'b0};
    cv[9]  = '{3'b100, 1'b0, 1'b1, 1'b0, 1'b1};
    cv[10] = '{3'b100, 1'b0, 1'b0, 1'b0, 1'b1};
    cv[11] = '{3'b100, 1'b1, 1'b0, 1'b0, 1'b0};
    cv[12] = '{3'b101, 1'b1, 1'b0, 1'b0, 1'b1};
    cv[13] = '{3'b101, 1'b0, 1'b1, 1'b0, 1'b1};
    cv[14] = '{3'b101, 1'b0, 1'b0, 1'b0, 1'b0};
    cv[15] = '{3'b110, 1'b0, 1'b0, 1'b1, 1'b1};
    cv[16] = '{3'b110, 1'b0, 1'b0, 1'b0, 1'b0};
    cv[17] = '{3'b111, 1'b1, 1'b1, 1'b1, 1'b1};
    cv[18] = '{3'b111, 1'b0, 1'b0, 1'b0, 1'b1};
    epc = pc_curr;
    for (int i = 0; i < 19; i++) begin
      branch_en = 1'b1;
      cond      = cv[i].c;
      flag_n    = cv[i].n;
      flag_z    = cv[i].z;
      flag_v    = cv[i].v;
      imm       = 9'd4;
      epc       = cv[i].tk ? epc + 16'd10 : epc + 16'd2;
      step();
      idle();
      check_st($sformatf("cond%0d", i), epc, cv[i].tk, 1'b0);
      if (cv[i].tk) begin
        step();
        epc = epc + 16'd2;
      end
    end

    // 5. wrap-around
    goto(16'hFFFE);
    check("plus2_wrap", pc_plus2, 16'h0000);
    step();
    check_st("seq_wrap", 16'h0000, 1'b0, 1'b0);
    goto(16'hFFF0);
    branch_en = 1'b1;
    cond      = 3'b111;
    imm       = 9'd8;
    step();
    idle();
    check_st("b_wrap_fwd", 16'h0002, 1'b1, 1'b0);
    step();
    branch_en = 1'b1;
    cond      = 3'b111;
    imm       = 9'h1F8;
    step();
    idle();
    check_st("b_wrap_back", 16'hFFF6, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_st("rst_in_flush", 16'h0000, 1'b0, 1'b0);

    // 6. halt
    goto(16'h0040);
    halt_dec = 1'b1;
    step();
    idle();
    check_st("halt", 16'h0040, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      branch_en  = 1'b1;
      branch_reg = i[0];
      cond       = 3'b111;
      imm        = 9'd4;
      reg_target = 16'h1234;
      step();
      check_st($sformatf("halt_hold%0d", i), 16'h0040, 1'b0, 1'b1);
    end
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_st("halt_rst", 16'h0000, 1'b0, 1'b0);
    step();
    check_st("post_rst", 16'h0002, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
